// File: rtl/pipeline_stall_controller_if.sv
// Handshake bundle between the pipeline control sources (hazard unit, EXE, MEM SRAM port)
// and the stall/flush sequencer.
interface pipeline_stall_controller_if #(
    parameter int CNT_W = 32
);
    logic             hazard;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             cnt_clr;
    logic             freeze_pc;
    logic             freeze_if_id;
    logic             bubble_id_exe;
    logic             flush_if_id;
    logic             flush_id_exe;
    logic             pc_sel_branch;
    logic             freeze_back;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] mem_wait_cnt;

    modport master (
        output hazard, branch_taken, mem_req, mem_ready, cnt_clr,
        input  freeze_pc, freeze_if_id, bubble_id_exe, flush_if_id, flush_id_exe,
               pc_sel_branch, freeze_back, mem_timeout, stall_cnt, flush_cnt, mem_wait_cnt
    );

    modport slave (
        input  hazard, branch_taken, mem_req, mem_ready, cnt_clr,
        output freeze_pc, freeze_if_id, bubble_id_exe, flush_if_id, flush_id_exe,
               pc_sel_branch, freeze_back, mem_timeout, stall_cnt, flush_cnt, mem_wait_cnt
    );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: arbitrates memory stalls, taken branches and
// RAW hazards, times out stuck SRAM accesses and keeps saturating performance counters.
module pipeline_stall_controller #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input logic                          clk,
    input logic                          rst,
    pipeline_stall_controller_if.slave   bus
);
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_e;

    state_e           state_q, state_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] mem_wait_cnt_q, mem_wait_cnt_d;

    logic mstall;
    logic inc_stall, inc_flush, inc_wait;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    assign mstall = bus.mem_req & ~bus.mem_ready;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d            = state_q;
        wait_cnt_d         = wait_cnt_q;
        inc_stall          = 1'b0;
        inc_flush          = 1'b0;
        inc_wait           = 1'b0;
        bus.freeze_pc      = 1'b0;
        bus.freeze_if_id   = 1'b0;
        bus.bubble_id_exe  = 1'b0;
        bus.flush_if_id    = 1'b0;
        bus.flush_id_exe   = 1'b0;
        bus.pc_sel_branch  = 1'b0;
        bus.freeze_back    = 1'b0;
        bus.mem_timeout    = 1'b0;

        if (state_q == ERR) begin
            bus.freeze_pc    = 1'b1;
            bus.freeze_if_id = 1'b1;
            bus.freeze_back  = 1'b1;
            bus.mem_timeout  = 1'b1;
        end else if (mstall) begin
            // Branch/hazard are deferred: the frozen stages re-present them after release.
            bus.freeze_pc    = 1'b1;
            bus.freeze_if_id = 1'b1;
            bus.freeze_back  = 1'b1;
            inc_wait         = 1'b1;
            if (state_q == RUN) begin
                state_d    = MEM_WAIT;
                wait_cnt_d = WC_W'(1);
            end else if (wait_cnt_q == WAIT_LAST) begin
                state_d = ERR;
            end else begin
                wait_cnt_d = wait_cnt_q + WC_W'(1);
            end
        end else begin
            state_d    = RUN;
            wait_cnt_d = '0;
            if (bus.branch_taken) begin
                bus.flush_if_id   = 1'b1;
                bus.flush_id_exe  = 1'b1;
                bus.pc_sel_branch = 1'b1;
                inc_flush         = 1'b1;
            end else if (bus.hazard) begin
                bus.freeze_pc     = 1'b1;
                bus.freeze_if_id  = 1'b1;
                bus.bubble_id_exe = 1'b1;
                inc_stall         = 1'b1;
            end
        end

        // Reset silences the pipeline controls in the same cycle, whatever state we are in.
        if (rst) begin
            bus.freeze_pc     = 1'b0;
            bus.freeze_if_id  = 1'b0;
            bus.bubble_id_exe = 1'b0;
            bus.flush_if_id   = 1'b0;
            bus.flush_id_exe  = 1'b0;
            bus.pc_sel_branch = 1'b0;
            bus.freeze_back   = 1'b0;
            bus.mem_timeout   = 1'b0;
        end

        if (bus.cnt_clr) begin
            stall_cnt_d    = '0;
            flush_cnt_d    = '0;
            mem_wait_cnt_d = '0;
        end else begin
            stall_cnt_d    = sat_inc(stall_cnt_q, inc_stall);
            flush_cnt_d    = sat_inc(flush_cnt_q, inc_flush);
            mem_wait_cnt_d = sat_inc(mem_wait_cnt_q, inc_wait);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            wait_cnt_q     <= '0;
            stall_cnt_q    <= '0;
            flush_cnt_q    <= '0;
            mem_wait_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
            mem_wait_cnt_q <= mem_wait_cnt_d;
        end
    end

    assign bus.stall_cnt    = stall_cnt_q;
    assign bus.flush_cnt    = flush_cnt_q;
    assign bus.mem_wait_cnt = mem_wait_cnt_q;
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller with a short timeout and narrow counters so the
// timeout and saturation corners are reachable in a few cycles.
module tb_pipeline_stall_controller;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;

    // Control vector order: freeze_pc, freeze_if_id, bubble, flush_if_id, flush_id_exe,
    // pc_sel_branch, freeze_back, mem_timeout.
    localparam logic [7:0] C_IDLE = 8'b0000_0000;
    localparam logic [7:0] C_HAZ  = 8'b1110_0000;
    localparam logic [7:0] C_BR   = 8'b0001_1100;
    localparam logic [7:0] C_MST  = 8'b1100_0010;
    localparam logic [7:0] C_ERR  = 8'b1100_0011;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    pipeline_stall_controller_if #(.CNT_W(CNT_W)) bus ();

    pipeline_stall_controller #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] ctl;
    assign ctl = {bus.freeze_pc, bus.freeze_if_id, bus.bubble_id_exe, bus.flush_if_id,
                  bus.flush_id_exe, bus.pc_sel_branch, bus.freeze_back, bus.mem_timeout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check the combinational controls mid-cycle, then clock it in.
    task automatic step(input string tag, input logic r, input logic h, input logic b,
                        input logic mq, input logic rdy, input logic clr, input logic [7:0] exp_ctl);
        @(negedge clk);
        rst              = r;
        bus.hazard       = h;
        bus.branch_taken = b;
        bus.mem_req      = mq;
        bus.mem_ready    = rdy;
        bus.cnt_clr      = clr;
        #1;
        check(tag, 32'(ctl), 32'(exp_ctl));
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnts(input string tag, input int s, input int f, input int w);
        check({tag, ".stall"}, 32'(bus.stall_cnt), 32'(s));
        check({tag, ".flush"}, 32'(bus.flush_cnt), 32'(f));
        check({tag, ".wait"},  32'(bus.mem_wait_cnt), 32'(w));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        bus.hazard = 1'b0; bus.branch_taken = 1'b0; bus.mem_req = 1'b0;
        bus.mem_ready = 1'b0; bus.cnt_clr = 1'b0;

        // 1: reset forces controls low even with every request asserted
        step("rst_all_req0", 1, 1, 1, 1, 0, 0, C_IDLE);
        step("rst_all_req1", 1, 1, 1, 1, 0, 0, C_IDLE);
        step("post_rst_idle", 0, 0, 0, 0, 0, 0, C_IDLE);
        check_cnts("post_rst", 0, 0, 0);

        // 2: two hazard cycles
        step("hazard0", 0, 1, 0, 0, 0, 0, C_HAZ);
        step("hazard1", 0, 1, 0, 0, 0, 0, C_HAZ);
        check_cnts("hazard", 2, 0, 0);

        // 3: clear, then branch wins over hazard
        step("clr", 0, 0, 0, 0, 0, 1, C_IDLE);
        check_cnts("clr", 0, 0, 0);
        step("br_haz", 0, 1, 1, 0, 0, 0, C_BR);
        check_cnts("br_haz", 0, 1, 0);

        // 4: three memory stall cycles with hazard pending, release on ready
        step("mst0", 0, 1, 0, 1, 0, 0, C_MST);
        step("mst1", 0, 1, 0, 1, 0, 0, C_MST);
        step("mst2", 0, 1, 0, 1, 0, 0, C_MST);
        step("mst_ready", 0, 1, 0, 1, 1, 0, C_HAZ);
        check_cnts("mst", 1, 1, 3);
        step("zero_wait", 0, 0, 0, 1, 1, 0, C_IDLE);

        // Release by dropping mem_req while waiting
        step("mst_single", 0, 0, 0, 1, 0, 0, C_MST);
        step("req_drop_br", 0, 0, 1, 0, 0, 0, C_BR);
        check_cnts("req_drop", 1, 2, 4);

        // 5: timeout after exactly MEM_TIMEOUT frozen cycles, sticky through ready
        for (int i = 0; i < MEM_TIMEOUT; i++)
            step($sformatf("to_mst%0d", i), 0, 0, 0, 1, 0, 0, C_MST);
        step("err_ready", 0, 0, 0, 1, 1, 0, C_ERR);
        step("err_br_haz", 0, 1, 1, 0, 0, 0, C_ERR);
        check_cnts("err", 1, 2, 8);
        step("err_rst", 1, 1, 1, 1, 0, 0, C_IDLE);
        step("after_err_rst", 0, 0, 0, 0, 0, 0, C_IDLE);
        check_cnts("after_err_rst", 0, 0, 0);

        // 6: saturation at 2^CNT_W-1, then clear beats same-cycle increment
        for (int i = 0; i < 20; i++)
            step($sformatf("sat%0d", i), 0, 1, 0, 0, 0, 0, C_HAZ);
        check("sat_stall", 32'(bus.stall_cnt), 32'd15);
        step("clr_haz", 0, 1, 0, 0, 0, 1, C_HAZ);
        check("clr_wins", 32'(bus.stall_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
